// File: rtl/tx_pkg.sv
// Shared definitions for the I2C TX buffer sequencer: word width default,
// shift FSM encoding and ping-pong buffer indices.
package tx_pkg;

    localparam int TX_WORD_W = 32;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    localparam logic BUF0 = 1'b0;
    localparam logic BUF1 = 1'b1;

endpackage

// File: rtl/tx_bit_counter.sv
// Bit counter for serial shifting: synchronous clear, count enable and a
// terminal-count flag on the last bit of a word.
module tx_bit_counter
    import tx_pkg::*;
#(
    parameter int WORD_W = TX_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/tx_buff_ctrl.sv
// Ping-pong sequencer for the double-buffered I2C TX datapath: loads host
// words alternately into two buffers and shifts each full buffer out serially.
module tx_buff_ctrl
    import tx_pkg::*;
#(
    parameter int WORD_W = TX_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StartTX,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [WORD_W-1:0] TXIn,
    output logic              LoadTXBuff0,
    output logic              LoadTXBuff1,
    output logic              ShiftTXBuff0,
    output logic              ShiftTXBuff1,
    output logic              passTXbuff,
    output logic              busy,
    output logic              word_done
);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [1:0]        r_full;
    logic [1:0]        w_full_next;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic              w_rd_ptr_next;
    logic              r_load_q;
    logic [WORD_W-1:0] r_txin;
    logic [1:0]        r_load;
    logic [1:0]        r_shift;
    logic [1:0]        w_load_next;
    logic [1:0]        w_shift_next;
    logic              r_word_done;
    logic              w_word_done_next;
    logic              w_accept;
    logic              w_end;
    logic              w_clr;
    logic              w_en;
    logic              w_tc;
    logic [CNT_W-1:0]  w_count;

    tx_bit_counter #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    // A load in flight blocks further writes so the pointer has settled first.
    assign wr_ready = !r_full[r_wr_ptr] && !r_load_q;
    assign w_accept = wr_valid && wr_ready;
    assign w_en     = (r_state == TX_SHIFT);
    assign w_end    = w_en && w_tc;

    always_comb begin
        w_state_next  = r_state;
        w_clr         = 1'b0;
        w_full_next   = r_full;
        w_rd_ptr_next = r_rd_ptr ^ w_end;

        // The loading buffer is never the shifting one, so both updates can land together.
        if (r_load_q) begin
            w_full_next[r_wr_ptr] = 1'b1;
        end
        if (w_end) begin
            w_full_next[r_rd_ptr] = 1'b0;
        end

        case (r_state)
            TX_IDLE: begin
                if (StartTX && r_full[r_rd_ptr]) begin
                    w_state_next = TX_SHIFT;
                    w_clr        = 1'b1;
                end
            end
            TX_SHIFT: begin
                if (w_tc) begin
                    w_clr = 1'b1;
                    if (StartTX && r_full[~r_rd_ptr]) begin
                        w_state_next = TX_SHIFT;
                    end else begin
                        w_state_next = TX_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = TX_IDLE;
            end
        endcase
    end

    // Strobes are computed one cycle ahead so the outputs come straight from flops.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        assign w_load_next[gi]  = w_accept && (r_wr_ptr == 1'(gi));
        assign w_shift_next[gi] = (w_state_next == TX_SHIFT) && (w_rd_ptr_next == 1'(gi));
    end

    assign w_word_done_next = w_en && !w_clr && (w_count == CNT_W'(WORD_W - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= TX_IDLE;
            r_full      <= 2'b00;
            r_wr_ptr    <= BUF0;
            r_rd_ptr    <= BUF0;
            r_load_q    <= 1'b0;
            r_txin      <= '0;
            r_load      <= 2'b00;
            r_shift     <= 2'b00;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_full      <= w_full_next;
            r_wr_ptr    <= r_wr_ptr ^ r_load_q;
            r_rd_ptr    <= w_rd_ptr_next;
            r_load_q    <= w_accept;
            r_load      <= w_load_next;
            r_shift     <= w_shift_next;
            r_word_done <= w_word_done_next;
            if (w_accept) begin
                r_txin <= wr_data;
            end
        end
    end

    assign TXIn         = r_txin;
    assign LoadTXBuff0  = r_load[BUF0];
    assign LoadTXBuff1  = r_load[BUF1];
    assign ShiftTXBuff0 = r_shift[BUF0];
    assign ShiftTXBuff1 = r_shift[BUF1];
    assign passTXbuff   = r_rd_ptr;
    assign word_done    = r_word_done;
    assign busy         = (r_state == TX_SHIFT) || r_full[BUF0] || r_full[BUF1] || r_load_q;

endmodule

// File: tb/tb_tx_buff_ctrl.sv
// Scoreboard bench for tx_buff_ctrl: a word-level reference model queues the
// expected loads and shift runs; a negedge monitor matches DUT activity to them.
module tb_tx_buff_ctrl;

    localparam int WORD_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              StartTX;
    logic              wr_valid;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;
    logic [WORD_W-1:0] TXIn;
    logic              LoadTXBuff0;
    logic              LoadTXBuff1;
    logic              ShiftTXBuff0;
    logic              ShiftTXBuff1;
    logic              passTXbuff;
    logic              busy;
    logic              word_done;

    tx_buff_ctrl #(.WORD_W(WORD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .StartTX      (StartTX),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .TXIn         (TXIn),
        .LoadTXBuff0  (LoadTXBuff0),
        .LoadTXBuff1  (LoadTXBuff1),
        .ShiftTXBuff0 (ShiftTXBuff0),
        .ShiftTXBuff1 (ShiftTXBuff1),
        .passTXbuff   (passTXbuff),
        .busy         (busy),
        .word_done    (word_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not happen (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {bit b; logic [WORD_W-1:0] d; int unsigned c;} load_exp_t;
    typedef struct {bit b; int unsigned c;} shift_exp_t;

    load_exp_t   exp_load_q[$];
    shift_exp_t  exp_shift_q[$];
    int unsigned cyc = 0;
    int unsigned m_wcnt = 0;
    int unsigned m_rcnt = 0;
    bit          m_fifo[$];
    bit          m_loading = 0;
    bit          m_load_buf = 0;
    bit          m_shifting = 0;
    int          m_left = 0;
    bit          m_acc_last = 0;

    function automatic bit model_ready();
        bit tgt;
        tgt = m_wcnt[0];
        if (m_loading) return 1'b0;
        foreach (m_fifo[i]) if (m_fifo[i] == tgt) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_busy();
        return m_shifting || (m_fifo.size() != 0) || m_loading;
    endfunction

    function automatic bit model_idle();
        return !m_shifting && (m_fifo.size() == 0) && !m_loading;
    endfunction

    // Words occupy buffers in arrival order; the front of m_fifo is the next to shift.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_wcnt = 0; m_rcnt = 0; m_fifo.delete();
            m_loading = 0; m_shifting = 0; m_left = 0; m_acc_last = 0;
            exp_load_q.delete(); exp_shift_q.delete();
        end else begin : step
            bit acc, ending, go;
            acc    = wr_valid && model_ready();
            ending = m_shifting && (m_left == 1);
            go     = StartTX && (m_shifting ? (ending && m_fifo.size() >= 2) : (m_fifo.size() >= 1));
            cyc++;
            if (ending) begin
                void'(m_fifo.pop_front());
                m_rcnt++;
            end
            if (m_loading) m_fifo.push_back(m_load_buf);
            if (go) begin
                m_shifting = 1;
                m_left     = WORD_W;
                exp_shift_q.push_back('{b: m_fifo[0], c: cyc});
            end else if (ending) begin
                m_shifting = 0;
            end else if (m_shifting) begin
                m_left--;
            end
            m_loading  = acc;
            m_acc_last = acc;
            if (acc) begin
                m_load_buf = m_wcnt[0];
                exp_load_q.push_back('{b: m_wcnt[0], d: wr_data, c: cyc});
                m_wcnt++;
            end
        end
    end

    // ---------------- monitor ----------------
    int cur_len = 0;
    bit cur_buf = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            cur_len = 0;
        end else begin : mon
            load_exp_t  le;
            shift_exp_t se;
            check("wr_ready", wr_ready, model_ready());
            check("busy", busy, model_busy());
            check("passTXbuff", passTXbuff, m_rcnt[0]);
            check("shift_exclusive", ShiftTXBuff0 && ShiftTXBuff1, 0);

            if (exp_load_q.size() > 0 && exp_load_q[0].c < cyc) begin
                fail_now("load_missing");
                void'(exp_load_q.pop_front());
            end
            if (LoadTXBuff0 || LoadTXBuff1) begin
                check("load_exclusive", LoadTXBuff0 && LoadTXBuff1, 0);
                if (exp_load_q.size() == 0) begin
                    fail_now("load_expected");
                end else begin
                    le = exp_load_q.pop_front();
                    check("load_buf", LoadTXBuff1, le.b);
                    check("load_TXIn", TXIn, le.d);
                    check("load_cycle", cyc, le.c);
                end
            end

            if (cur_len == 0 && exp_shift_q.size() > 0 && exp_shift_q[0].c < cyc) begin
                fail_now("shift_missing");
                void'(exp_shift_q.pop_front());
            end
            if (ShiftTXBuff0 || ShiftTXBuff1) begin
                if (cur_len == 0) begin
                    if (exp_shift_q.size() == 0) begin
                        fail_now("shift_expected");
                        cur_buf = ShiftTXBuff1;
                    end else begin
                        se = exp_shift_q.pop_front();
                        cur_buf = se.b;
                        check("shift_buf", ShiftTXBuff1, se.b);
                        check("shift_start_cycle", cyc, se.c);
                    end
                end else begin
                    check("shift_steady_buf", ShiftTXBuff1, cur_buf);
                end
                cur_len++;
                check("word_done", word_done, cur_len == WORD_W);
                if (cur_len == WORD_W) cur_len = 0;
            end else begin
                if (cur_len != 0) begin
                    fail_now("shift_run_length");
                    cur_len = 0;
                end
                check("word_done_idle", word_done, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_phase = 0;

    task automatic tick();
        @(negedge clk);
        if (rand_phase && $urandom_range(0, 15) == 0) StartTX = !StartTX;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input int budget);
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (m_acc_last) begin
                wr_valid = 1'b0;
                return;
            end
        end
        wr_valid = 1'b0;
        fail_now("accept_timeout");
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (model_idle()) return;
        end
        fail_now("idle_timeout");
    endtask

    task automatic wait_shift_cycle(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_shifting && m_left == WORD_W - n) return;
        end
        fail_now("shift_cycle_timeout");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_TXIn"}, TXIn, 0);
        check({tag, "_LoadTXBuff0"}, LoadTXBuff0, 0);
        check({tag, "_LoadTXBuff1"}, LoadTXBuff1, 0);
        check({tag, "_ShiftTXBuff0"}, ShiftTXBuff0, 0);
        check({tag, "_ShiftTXBuff1"}, ShiftTXBuff1, 0);
        check({tag, "_passTXbuff"}, passTXbuff, 0);
        check({tag, "_word_done"}, word_done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; StartTX = 1'b0; wr_valid = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("reset_wr_ready", wr_ready, 1);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single word
        StartTX = 1'b1;
        send_word(32'd67, 20);
        wait_idle(100);

        // Back-to-back, gapless across the buffer boundary
        send_word(32'h0000_0043, 20);
        send_word(32'hA5A5_A5A5, 20);
        wait_idle(150);

        // Backpressure with both buffers full
        StartTX = 1'b0;
        fork
            begin
                send_word(32'h1111_0001, 20);
                send_word(32'h2222_0002, 20);
                send_word(32'h3333_0003, 200);
            end
            begin
                repeat (12) @(negedge clk);
                check("bp_wr_ready_full", wr_ready, 0);
                check("bp_busy", busy, 1);
                StartTX = 1'b1;
            end
        join
        wait_idle(150);

        // StartTX dropped mid-word: current word completes, buffer 1 waits
        send_word(32'hDEAD_BEEF, 20);
        send_word(32'hCAFE_F00D, 20);
        wait_shift_cycle(10, 60);
        StartTX = 1'b0;
        repeat (40) @(negedge clk);
        check("drop_shift0", ShiftTXBuff0, 0);
        check("drop_shift1", ShiftTXBuff1, 0);
        check("drop_busy", busy, 1);
        check("drop_pass", passTXbuff, 1);
        StartTX = 1'b1;
        wait_idle(100);

        // Asynchronous reset in the middle of a shift
        send_word(32'h0BAD_F00D, 20);
        wait_shift_cycle(15, 60);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_reset_wr_ready", wr_ready, 1);
        send_word(32'h0000_1234, 20);
        wait_idle(100);

        // Randomized traffic with StartTX toggling
        rand_phase = 1;
        for (int w = 0; w < 40; w++) begin
            int gap;
            gap = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) gap = $urandom_range(20, 45);
            repeat (gap) tick();
            send_word($urandom(), 400);
        end
        rand_phase = 0;
        StartTX = 1'b1;
        wait_idle(300);
        repeat (3) @(negedge clk);

        check("leftover_loads", exp_load_q.size(), 0);
        check("leftover_shifts", exp_shift_q.size(), 0);
        check("open_shift_run", cur_len, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_buff_ctrl.md
Name: tx_buff_ctrl

Overview:
- Sequencer for the double-buffered I2C TX datapath (txDataPath).
- Accepts 32-bit words from the host over a valid/ready handshake and loads them alternately into TXBuff0 and TXBuff1.
- Shifts each full buffer out serially through txDataPath and steers passTXbuff to the buffer being shifted.
- Ping-pong operation lets the host refill one buffer while the other shifts, so back-to-back words go out gaplessly.

Parameters:
- WORD_W, 32, width of TXIn and of each TX buffer; also the number of shift cycles per word.
- CNT_W, $clog2(WORD_W), width of the internal bit counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- StartTX  in  1  transmit enable; gates the start of each new word.
- wr_valid  in  1  host word valid.
- wr_data  in  WORD_W  host word.
- wr_ready  out  1  controller can accept a word this cycle.
- TXIn  out  WORD_W  registered word driven to the datapath load input.
- LoadTXBuff0  out  1  one-cycle load strobe, buffer 0.
- LoadTXBuff1  out  1  one-cycle load strobe, buffer 1.
- ShiftTXBuff0  out  1  shift enable, buffer 0.
- ShiftTXBuff1  out  1  shift enable, buffer 1.
- passTXbuff  out  1  output mux select: 0 = buffer 0, 1 = buffer 1.
- busy  out  1  high while a word is shifting or either buffer is full.
- word_done  out  1  one-cycle pulse on the last shift cycle of each word.

Behaviour:
- Timing convention: "cycle n" is the period following rising edge n. All outputs are registered except wr_ready and busy, which are combinational from state.
- Reset values: all outputs 0; TXIn = 0; full0 = full1 = 0; wr_ptr = rd_ptr = 0; bit counter = 0; FSM = IDLE.
- Reset mid-word drops the shift enables immediately and discards all buffered words.
- Internal state:
  - full[1:0]: per-buffer occupancy flags.
  - wr_ptr: next buffer to load.
  - rd_ptr: next buffer to shift.
  - load_q: a load strobe is in flight.
- Write path:
  - wr_ready = !full[wr_ptr] && !load_q.
  - Accept at edge t (wr_valid && wr_ready): TXIn <= wr_data; load_q <= 1.
  - In cycle t, LoadTXBuff[wr_ptr] = 1 for exactly one cycle.
  - At edge t+1: full[wr_ptr] <= 1; wr_ptr toggles; load_q <= 0.
  - Peak throughput is one word per 2 cycles.
  - Loads never target a full buffer. Load and shift are never on the same buffer in the same cycle.
- Shift FSM, states IDLE and SHIFT:
  - IDLE: if StartTX && full[rd_ptr], go to SHIFT with counter = 0.
  - SHIFT: ShiftTXBuff[rd_ptr] = 1; the other shift enable is 0; the counter increments every cycle.
  - End of word: when counter == WORD_W-1, word_done = 1 that cycle. At the next edge: full[rd_ptr] <= 0 and rd_ptr toggles. If StartTX && full[other], stay in SHIFT with counter = 0 (gapless back-to-back); otherwise go to IDLE.
  - Exactly WORD_W shift-enable cycles per word, never more and never fewer.
- Latency: a word accepted at edge t into an idle controller with StartTX = 1 shifts in cycles t+2 .. t+2+WORD_W-1.
- passTXbuff tracks rd_ptr: it equals the buffer being shifted during SHIFT and holds the next buffer in IDLE. It changes only at word boundaries.
- StartTX deasserted mid-word: the current word completes; no new word starts until StartTX = 1 again.
- Both buffers full: wr_ready = 0 until the shifting word finishes. A freed buffer is writable in the cycle after the freeing edge.
- A load completing on the same edge a word ends: full is set for one buffer and cleared for the other. Both updates apply and do not conflict.
- busy = (state == SHIFT) || full0 || full1 || load_q.

Decomposition:
- Shared package tx_pkg holds:
  - the WORD_W default;
  - the state encoding (TX_IDLE = 1'b0, TX_SHIFT = 1'b1);
  - buffer index constants (BUF0 = 0, BUF1 = 1).
- One natural sub-module, tx_bit_counter: a CNT_W-bit counter with clear, enable and a terminal-count flag at WORD_W-1. It is reused later by the RX controller.

Test Plan:
- Single word: StartTX = 1; write 32'd67 -> LoadTXBuff0 pulses one cycle with TXIn = 67; ShiftTXBuff0 high exactly 32 cycles; passTXbuff = 0; one word_done pulse; busy falls afterwards.
- Back-to-back: write 32'h0000_0043, then 32'hA5A5_A5A5 -> second word loads into buffer 1 during the first shift; ShiftTXBuff1 rises the cycle after ShiftTXBuff0 falls; passTXbuff toggles 0 -> 1 at the boundary; 64 contiguous shift cycles in total.
- Backpressure: with StartTX = 0, hold wr_valid = 1 for three words -> two accepted; wr_ready = 0 with both full. Raise StartTX -> the third word is accepted the cycle after buffer 0 frees.
- StartTX drop: deassert StartTX at shift cycle 10 with buffer 1 full -> word 0 completes all 32 cycles; FSM goes IDLE; buffer 1 waits. Reassert -> buffer 1 shifts 32 cycles.
- Async reset mid-shift: assert rst at shift cycle 15 -> all outputs 0 immediately without waiting for a clock edge; after release, wr_ready = 1 and the next word goes to buffer 0.
